// File: rtl/lsm_pkg.sv
// lsm_pkg: shared types, constants and FSM states for the LSM decision datapath
package lsm_pkg;
    localparam int QINT          = 16;
    localparam int QFRAC         = 16;
    localparam int DEF_WIDTH     = QINT + QFRAC;
    localparam int DEF_MAX_PATHS = 4096;
    localparam int DEF_MAX_STEPS = 256;
    localparam int DEF_MAX_OUT   = 8;
    localparam int PATH_W        = $clog2(DEF_MAX_PATHS);
    localparam int PATH_CNT_W    = $clog2(DEF_MAX_PATHS + 1);
    localparam int STEP_W        = $clog2(DEF_MAX_STEPS);
    localparam int STEP_CNT_W    = $clog2(DEF_MAX_STEPS + 1);
    typedef logic signed [DEF_WIDTH-1:0] beta_t;
    typedef beta_t [0:2] beta_vec_t;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_BETA, S_ISSUE, S_DRAIN, S_FINISH} state_t;
endpackage

// File: rtl/lsm_credit_counter.sv
// lsm_credit_counter: issued-but-unreturned transaction count with a full flag
module lsm_credit_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full
);
    // an issue and a return in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (inc && !dec) count <= count + CW'(1);
        else if (dec && !inc) count <= count - CW'(1);
    end
    assign full = count == CW'(MAX);
endmodule

// File: rtl/lsm_step_sequencer.sv
// lsm_step_sequencer: backward-induction step controller feeding lsm_decision
module lsm_step_sequencer
    import lsm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_PATHS = DEF_MAX_PATHS,
    parameter int MAX_STEPS = DEF_MAX_STEPS,
    parameter int MAX_OUT   = DEF_MAX_OUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(MAX_PATHS+1)-1:0]    num_paths,
    input  logic [$clog2(MAX_STEPS+1)-1:0]    num_steps,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(MAX_STEPS)-1:0]      step_idx,
    input  logic                              beta_valid,
    output logic                              beta_ready,
    input  logic signed [3*WIDTH-1:0]         beta_in,
    output logic signed [3*WIDTH-1:0]         beta_out,
    output logic                              dec_valid,
    input  logic                              dec_ready,
    output logic [$clog2(MAX_PATHS)-1:0]      dec_path_idx,
    input  logic                              res_valid,
    output logic                              res_ready,
    output logic                              pv_wr_en,
    output logic [$clog2(MAX_PATHS)-1:0]      pv_wr_addr,
    input  logic                              pv_wr_ready
);
    localparam int PW  = $clog2(MAX_PATHS);
    localparam int PCW = $clog2(MAX_PATHS + 1);
    localparam int SW  = $clog2(MAX_STEPS);
    localparam int SCW = $clog2(MAX_STEPS + 1);
    localparam int OW  = $clog2(MAX_OUT + 1);
    state_t         r_state;
    logic [PCW-1:0] r_num_paths;
    logic [PCW-1:0] r_issue_cnt;
    logic [PCW-1:0] r_ret_cnt;
    logic [OW-1:0]  w_out;
    logic           w_full;
    logic           w_active;
    logic           w_issue;
    logic           w_acc;
    logic           w_last_issue;
    logic           w_ret_done;
    assign w_active     = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign beta_ready   = r_state == S_WAIT_BETA;
    assign dec_valid    = (r_state == S_ISSUE) && (r_issue_cnt < r_num_paths) && !w_full;
    assign dec_path_idx = r_issue_cnt[PW-1:0];
    assign res_ready    = w_active && pv_wr_ready;
    assign w_acc        = res_valid && res_ready && (w_out != '0);
    assign pv_wr_en     = w_acc;
    assign pv_wr_addr   = r_ret_cnt[PW-1:0];
    assign w_issue      = dec_valid && dec_ready;
    assign w_last_issue = w_issue && (r_issue_cnt + PCW'(1) == r_num_paths);
    assign w_ret_done   = (r_ret_cnt == r_num_paths) || (w_acc && (r_ret_cnt + PCW'(1) == r_num_paths));
    lsm_credit_counter #(.MAX(MAX_OUT), .CW(OW)) u_credit (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_issue),
        .dec   (w_acc),
        .count (w_out),
        .full  (w_full)
    );
    // step FSM: beta capture, path issue/return counting and run bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_paths <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            step_idx    <= '0;
            beta_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_issue) r_issue_cnt <= r_issue_cnt + PCW'(1);
            if (w_acc) r_ret_cnt <= r_ret_cnt + PCW'(1);
            case (r_state)
                S_IDLE: if (start) begin
                    busy        <= 1'b1;
                    r_num_paths <= num_paths;
                    if (num_paths == '0 || num_steps < SCW'(2)) r_state <= S_FINISH;
                    else begin
                        step_idx <= SW'(num_steps - SCW'(1));
                        r_state  <= S_WAIT_BETA;
                    end
                end
                S_WAIT_BETA: if (beta_valid) begin
                    beta_out    <= beta_in;
                    r_issue_cnt <= '0;
                    r_ret_cnt   <= '0;
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: if (w_last_issue) r_state <= S_DRAIN;
                S_DRAIN: if (w_ret_done) begin
                    if (step_idx == SW'(1)) r_state <= S_FINISH;
                    else begin
                        step_idx <= step_idx - SW'(1);
                        r_state  <= S_WAIT_BETA;
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsm_step_sequencer.sv
// tb_lsm_step_sequencer: directed checks of the LSM step sequencer against a delay-line decision model
module tb_lsm_step_sequencer;
    localparam int WIDTH = 32, MAX_PATHS = 16, MAX_STEPS = 8, MAX_OUT = 2;
    logic        clk = 0, rst = 1, start = 0;
    logic [4:0]  num_paths = 0;
    logic [3:0]  num_steps = 0;
    logic        busy, done;
    logic [2:0]  step_idx;
    logic        beta_valid = 0, beta_ready;
    logic [95:0] beta_in = 0, beta_out;
    logic        dec_valid, dec_ready = 1;
    logic [3:0]  dec_path_idx;
    logic        res_valid, res_ready, pv_wr_en;
    logic [3:0]  pv_wr_addr;
    logic        pv_wr_ready = 1;

    lsm_step_sequencer #(.WIDTH(WIDTH), .MAX_PATHS(MAX_PATHS), .MAX_STEPS(MAX_STEPS), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_paths(num_paths), .num_steps(num_steps),
        .busy(busy), .done(done), .step_idx(step_idx),
        .beta_valid(beta_valid), .beta_ready(beta_ready), .beta_in(beta_in), .beta_out(beta_out),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_path_idx(dec_path_idx),
        .res_valid(res_valid), .res_ready(res_ready),
        .pv_wr_en(pv_wr_en), .pv_wr_addr(pv_wr_addr), .pv_wr_ready(pv_wr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] bval(input int s);
        return {32'(s) + 32'h3000_0000, 32'(s) + 32'h2000_0000, 32'(s) + 32'h1000_0000};
    endfunction

    int n_vec = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // decision unit model: fixed latency, in-order results held until accepted
    int cyc = 0, lat = 3, wp = 0, rp = 0;
    int rt [16];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            wp <= 0;
            rp <= 0;
        end else begin
            if (dec_valid && dec_ready) begin
                rt[wp % 16] <= cyc + lat;
                wp <= wp + 1;
            end
            if (res_valid && res_ready) rp <= rp + 1;
        end
    end
    assign res_valid = (wp != rp) && (cyc >= rt[rp % 16]);

    // monitors
    int wn = 0, bn = 0, n_iss = 0, n_done = 0, last_wr = 0, done_at = 0;
    int wlog [256];
    int blog [64];
    int stall_bad = 0, pv_bad = 0, crd_bad = 0, max_out = 0, busy_bad = 0, wait_keep = 0, wait_dec = 0;
    logic       prev_stall = 0;
    logic [3:0] prev_idx = 0;
    always @(posedge clk) begin
        if (pv_wr_en) begin
            wlog[wn] <= int'(pv_wr_addr);
            wn <= wn + 1;
            last_wr <= cyc;
        end
        if (beta_valid && beta_ready) begin
            blog[bn] <= int'(step_idx);
            bn <= bn + 1;
        end
        if (dec_valid && dec_ready) n_iss <= n_iss + 1;
        if (done) begin
            n_done <= n_done + 1;
            done_at <= cyc;
        end
        if (done && busy) busy_bad <= busy_bad + 1;
        if (pv_wr_en && !pv_wr_ready) pv_bad <= pv_bad + 1;
        if (dec_valid && (wp - rp) >= MAX_OUT) crd_bad <= crd_bad + 1;
        if ((wp - rp) > max_out) max_out <= wp - rp;
        if (prev_stall && !(dec_valid && dec_path_idx == prev_idx)) stall_bad <= stall_bad + 1;
        prev_stall <= dec_valid && !dec_ready && !rst;
        prev_idx <= dec_path_idx;
        if (beta_ready && step_idx == 3'd2) begin
            if (beta_out == bval(3)) wait_keep <= wait_keep + 1;
            if (dec_valid) wait_dec <= wait_dec + 1;
        end
    end

    // regression engine model: beta offered while ready, optionally delayed at one step
    int slow_step = 99;
    initial begin
        int w = 0;
        forever begin
            @(negedge clk);
            w = beta_ready ? w + 1 : 0;
            beta_valid = beta_ready && (w > ((int'(step_idx) == slow_step) ? 10 : 0));
            beta_in = beta_valid ? bval(int'(step_idx)) : 96'hDEAD_BEEF_0BAD_F00D_CAFE_0001;
        end
    end

    // decision-ready and PV-memory-ready drivers
    bit rnd_dec = 0;
    int pv_low_from = -100;
    initial begin
        forever begin
            @(negedge clk);
            dec_ready = rnd_dec ? 1'($urandom_range(0, 1)) : 1'b1;
            pv_wr_ready = !(cyc >= pv_low_from && cyc < pv_low_from + 4);
        end
    end

    task automatic run(input int np, input int ns, input int restart_at, output int t);
        t = 0;
        num_paths = 5'(np);
        num_steps = 4'(ns);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
            if (t == restart_at) begin
                num_paths = 5'd1;
                num_steps = 4'd2;
                start = 1;
            end else start = 0;
        end
        chk("done_seen", done, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_run(input string tag, input int w0, input int b0, input int d0, input int np, input int ns);
        chk({tag, "_wcount"}, wn - w0, np * (ns - 1));
        for (int i = 0; i < np * (ns - 1); i++) chk({tag, "_addr"}, wlog[w0 + i], i % np);
        chk({tag, "_betas"}, bn - b0, ns - 1);
        for (int i = 0; i < ns - 1; i++) chk({tag, "_step"}, blog[b0 + i], ns - 1 - i);
        chk({tag, "_done_cnt"}, n_done - d0, 1);
    endtask

    initial begin
        int t, w0, b0, d0, i0, k0, q0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_beta_ready", beta_ready, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_pv_wr_en", pv_wr_en, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_beta_out", beta_out, 0);
        rst = 0;
        @(negedge clk);

        // full run, ignored restart while busy
        w0 = wn; b0 = bn; d0 = n_done;
        run(5, 4, 10, t);
        chk_run("basic", w0, b0, d0, 5, 4);
        chk("basic_done_lat", done_at - last_wr, 2);
        chk("basic_beta_final", beta_out, bval(1));

        // credit limit with a slower decision unit
        lat = 5;
        w0 = wn; b0 = bn; d0 = n_done;
        run(5, 2, 0, t);
        chk_run("credit", w0, b0, d0, 5, 2);
        chk("credit_max_out", max_out, MAX_OUT);

        // random decision back-pressure and a PV-memory stall
        lat = 3;
        rnd_dec = 1;
        pv_low_from = cyc + 8;
        w0 = wn; b0 = bn; d0 = n_done;
        run(6, 2, 0, t);
        rnd_dec = 0;
        chk_run("stall", w0, b0, d0, 6, 2);
        chk("stall_idx_stable", stall_bad, 0);
        chk("stall_pv_gate", pv_bad, 0);

        // late beta at step 2
        slow_step = 2;
        w0 = wn; b0 = bn; d0 = n_done; k0 = wait_keep; q0 = wait_dec;
        run(3, 4, 0, t);
        slow_step = 99;
        chk_run("slow", w0, b0, d0, 3, 4);
        chk("slow_beta_held", wait_keep - k0, 11);
        chk("slow_no_issue", wait_dec - q0, 0);

        // zero paths
        b0 = bn; d0 = n_done; i0 = n_iss;
        run(0, 4, 0, t);
        chk("zero_done_lat", t, 1);
        chk("zero_betas", bn - b0, 0);
        chk("zero_issues", n_iss - i0, 0);
        chk("zero_done_cnt", n_done - d0, 1);

        // reset mid-ISSUE at step 2, then a clean run
        num_paths = 5'd5;
        num_steps = 4'd4;
        start = 1;
        @(negedge clk);
        start = 0;
        t = 0;
        while (!(step_idx == 3'd2 && dec_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach", step_idx == 3'd2 && dec_valid, 1);
        d0 = n_done;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_beta_ready", beta_ready, 0);
        chk("abort_dec_valid", dec_valid, 0);
        chk("abort_res_ready", res_ready, 0);
        chk("abort_pv_wr_en", pv_wr_en, 0);
        chk("abort_step_idx", step_idx, 0);
        chk("abort_beta_out", beta_out, 0);
        chk("abort_path_idx", dec_path_idx, 0);
        chk("abort_pv_addr", pv_wr_addr, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        w0 = wn; b0 = bn; d0 = n_done;
        run(4, 3, 0, t);
        chk_run("after_abort", w0, b0, d0, 4, 3);

        chk("credit_limit", crd_bad, 0);
        chk("busy_with_done", busy_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
